// File: rtl/mem_pkg.sv
// Shared size encodings, FSM state type and byte-lane helpers for the MEM stage.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Byte enables for an access of the given size starting at byte lane 'lane'.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << lane;
      SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      default: bad = |lane;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Word-organised data memory with per-byte write enables, synchronous write and
// combinational read. Contents are intentionally not reset.
module mem_stage_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: sized loads/stores with configurable wait states, BEQ/BNE
// resolution and the MEM/WB register.
module mem_stage_param
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int REG_W       = 5,
  parameter int PC_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      store_data,
  input  logic [REG_W-1:0] rd,
  input  logic [PC_W-1:0]  pc_branch,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       mem_size,
  input  logic             load_unsigned,
  input  logic             zero,
  input  logic             branch,
  input  logic             branch_ne,
  output logic             stall,
  output logic             pc_src,
  output logic [PC_W-1:0]  pc_branch_out,
  output logic             wb_valid,
  output logic [31:0]      wb_alu,
  output logic [31:0]      wb_load,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_misalign
);

  localparam int AW = $clog2(DEPTH);

  mem_state_e  state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        mem_op, misalign, access, complete, mem_we;
  logic [1:0]  lane;
  logic [31:0] rdata, wdata, shifted, load_ext;

  assign lane     = alu_result[1:0];
  assign mem_op   = mem_read | mem_write;
  assign misalign = mem_op & is_misaligned(mem_size, lane);
  assign access   = in_valid & mem_op & ~misalign;
  // Writes land only on the completing edge; a reset in progress drops them.
  assign mem_we   = complete & access & mem_write & reset_n;

  always_comb begin
    case (mem_size)
      SZ_BYTE: wdata = {4{store_data[7:0]}};
      SZ_HALF: wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase
  end

  mem_stage_dmem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clock (clock),
    .we    (mem_we),
    .be    (lane_mask(mem_size, lane)),
    .addr  (alu_result[AW+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    shifted  = rdata >> {lane, 3'b000};
    load_ext = '0;
    if (mem_read && !misalign) begin
      case (mem_size)
        SZ_BYTE: load_ext = load_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
        SZ_HALF: load_ext = load_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
        default: load_ext = rdata;
      endcase
    end
  end

  // Stall covers the acceptance cycle and all but the last wait cycle, so the
  // upstream advances on the same edge that completes the access.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall        = 1'b0;
    complete     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (access && WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'(WAIT_STATES - 1);
            stall        = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall        = 1'b1;
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      wb_valid    <= 1'b0;
      wb_alu      <= '0;
      wb_load     <= '0;
      wb_rd       <= '0;
      wb_misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      wb_valid <= complete;
      if (complete) begin
        wb_alu      <= alu_result;
        wb_load     <= load_ext;
        wb_rd       <= rd;
        wb_misalign <= misalign;
      end
    end
  end

  assign pc_src        = in_valid & branch & (zero ^ branch_ne);
  assign pc_branch_out = pc_branch;

endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param: one instance with no wait states, one with three,
// each checked by a queue of expected MEM/WB results built from a byte model.
module tb_mem_stage_param;
  import mem_pkg::*;

  typedef struct packed {
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [31:0] pc_branch;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic        zero;
    logic        branch;
    logic        branch_ne;
  } stim_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] load;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  stim_t s0, s3;

  logic        stall0, pc_src0, wb_valid0, wb_mis0;
  logic [31:0] pcb0, wb_alu0, wb_load0;
  logic [4:0]  wb_rd0;
  logic        stall3, pc_src3, wb_valid3, wb_mis3;
  logic [31:0] pcb3, wb_alu3, wb_load3;
  logic [4:0]  wb_rd3;

  exp_t q0[$];
  exp_t q3[$];
  logic [7:0] mref0 [int];
  logic [7:0] mref3 [int];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_stage_param #(.DEPTH(256), .WAIT_STATES(0), .REG_W(5), .PC_W(32)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(s0.in_valid), .alu_result(s0.alu_result),
    .store_data(s0.store_data), .rd(s0.rd), .pc_branch(s0.pc_branch), .mem_read(s0.mem_read),
    .mem_write(s0.mem_write), .mem_size(s0.mem_size), .load_unsigned(s0.load_unsigned),
    .zero(s0.zero), .branch(s0.branch), .branch_ne(s0.branch_ne), .stall(stall0),
    .pc_src(pc_src0), .pc_branch_out(pcb0), .wb_valid(wb_valid0), .wb_alu(wb_alu0),
    .wb_load(wb_load0), .wb_rd(wb_rd0), .wb_misalign(wb_mis0)
  );

  mem_stage_param #(.DEPTH(256), .WAIT_STATES(3), .REG_W(5), .PC_W(32)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(s3.in_valid), .alu_result(s3.alu_result),
    .store_data(s3.store_data), .rd(s3.rd), .pc_branch(s3.pc_branch), .mem_read(s3.mem_read),
    .mem_write(s3.mem_write), .mem_size(s3.mem_size), .load_unsigned(s3.load_unsigned),
    .zero(s3.zero), .branch(s3.branch), .branch_ne(s3.branch_ne), .stall(stall3),
    .pc_src(pc_src3), .pc_branch_out(pcb3), .wb_valid(wb_valid3), .wb_alu(wb_alu3),
    .wb_load(wb_load3), .wb_rd(wb_rd3), .wb_misalign(wb_mis3)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] sz, input logic [1:0] ln);
    if (sz == SZ_BYTE) return 1'b0;
    if (sz == SZ_HALF) return ln[0];
    return ln != 2'b00;
  endfunction

  function automatic int byte_key(input logic [31:0] a, input int i);
    logic [31:0] k;
    k = {22'b0, a[9:2], 2'(i)};
    return int'(k);
  endfunction

  function automatic logic [31:0] model_word(input int which, input logic [31:0] a);
    logic [31:0] w;
    int k;
    for (int i = 0; i < 4; i++) begin
      k = byte_key(a, i);
      if (which == 3) w[i*8 +: 8] = mref3.exists(k) ? mref3[k] : 8'hxx;
      else            w[i*8 +: 8] = mref0.exists(k) ? mref0[k] : 8'hxx;
    end
    return w;
  endfunction

  function automatic logic [31:0] model_load(input int which, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
    logic [31:0] w, sh;
    w  = model_word(which, a);
    sh = w >> (8 * a[1:0]);
    if (sz == SZ_BYTE) return uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    if (sz == SZ_HALF) return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return w;
  endfunction

  task automatic model_store(input int which, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
    logic en;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      if (sz == SZ_BYTE)      begin en = (i == int'(a[1:0])); b = d[7:0]; end
      else if (sz == SZ_HALF) begin en = ((i / 2) == int'(a[1])); b = d[(i % 2)*8 +: 8]; end
      else                    begin en = 1'b1; b = d[i*8 +: 8]; end
      if (en) begin
        if (which == 3) mref3[byte_key(a, i)] = b;
        else            mref0[byte_key(a, i)] = b;
      end
    end
  endtask

  function automatic logic stall_of(input int which);
    return (which == 3) ? stall3 : stall0;
  endfunction

  function automatic logic wbv_of(input int which);
    return (which == 3) ? wb_valid3 : wb_valid0;
  endfunction

  task automatic push_exp(input int which, input exp_t e);
    if (which == 3) q3.push_back(e);
    else            q0.push_back(e);
  endtask

  // Drives one instruction, checks the stall length, returns just after completion.
  task automatic apply_stimulus(input int which, input logic rd_en, input logic wr_en,
                                input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                                input logic [31:0] data, input logic [4:0] rdi);
    exp_t e;
    stim_t s;
    logic mis;
    int exp_stall, n;
    mis   = (rd_en | wr_en) ? model_mis(sz, addr[1:0]) : 1'b0;
    e.alu = addr;
    e.rd  = rdi;
    e.mis = mis;
    e.load = (rd_en && !mis) ? model_load(which, sz, uns, addr) : 32'h0;
    if (wr_en && !mis) model_store(which, sz, addr, data);
    push_exp(which, e);
    s = '0;
    s.in_valid = 1'b1; s.alu_result = addr; s.store_data = data; s.rd = rdi;
    s.mem_read = rd_en; s.mem_write = wr_en; s.mem_size = sz; s.load_unsigned = uns;
    if (which == 3) s3 = s; else s0 = s;
    exp_stall = (which == 3 && (rd_en || wr_en) && !mis) ? 3 : 0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (stall_of(which) !== 1'b1) break;
      n++;
      if (n > 1) check_output("wb_valid_during_wait", 32'(wbv_of(which)), 32'h0);
    end
    check_output("stall_cycles", n, exp_stall);
    @(posedge clock);
    #1;
    if (which == 3) s3.in_valid = 1'b0; else s0.in_valid = 1'b0;
  endtask

  task automatic compare_wb(input string tag, input int qsize, input exp_t e, input logic [31:0] alu,
                            input logic [31:0] ld, input logic [4:0] r, input logic mis);
    checks++;
    assert (qsize != 0) else begin
      errors++;
      $error("[TB] FAIL %s_spurious: observed=wb_valid expected=no completion", tag);
    end
    if (qsize != 0) begin
      check_output({tag, "_alu"}, alu, e.alu);
      check_output({tag, "_load"}, ld, e.load);
      check_output({tag, "_rd"}, 32'(r), 32'(e.rd));
      check_output({tag, "_misalign"}, 32'(mis), 32'(e.mis));
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    int sz;
    if (wb_valid0 === 1'b1) begin
      sz = q0.size();
      e = '{default: '0};
      if (sz != 0) e = q0.pop_front();
      compare_wb("wb0", sz, e, wb_alu0, wb_load0, wb_rd0, wb_mis0);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    int sz;
    if (wb_valid3 === 1'b1) begin
      sz = q3.size();
      e = '{default: '0};
      if (sz != 0) e = q3.pop_front();
      compare_wb("wb3", sz, e, wb_alu3, wb_load3, wb_rd3, wb_mis3);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    s0 = '0;
    s3 = '0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_wb_valid0", 32'(wb_valid0), 32'h0);
    check_output("rst_wb_alu0", wb_alu0, 32'h0);
    check_output("rst_stall3", 32'(stall3), 32'h0);
    check_output("rst_wb_valid3", 32'(wb_valid3), 32'h0);
    check_output("rst_wb_load3", wb_load3, 32'h0);
    check_output("rst_wb_rd3", 32'(wb_rd3), 32'h0);
    check_output("rst_wb_mis3", 32'(wb_mis3), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // No wait states: sized stores and loads with extension.
    apply_stimulus(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1);
    apply_stimulus(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd2);
    check_output("ws0_load_word", wb_load0, 32'hDEADBEEF);
    apply_stimulus(0, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h80, 5'd3);
    apply_stimulus(0, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 5'd4);
    check_output("ws0_load_sbyte", wb_load0, 32'hFFFFFF80);
    apply_stimulus(0, 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 5'd5);
    check_output("ws0_load_ubyte", wb_load0, 32'h00000080);
    apply_stimulus(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd6);
    check_output("ws0_word_after_byte", wb_load0, 32'h80ADBEEF);
    apply_stimulus(0, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h16, 32'h0000A55A, 5'd7);
    apply_stimulus(0, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, 5'd8);
    check_output("ws0_load_shalf", wb_load0, 32'hFFFFA55A);
    apply_stimulus(0, 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, 5'd9);
    check_output("ws0_load_uhalf", wb_load0, 32'h0000A55A);

    // Misaligned accesses are suppressed and flagged.
    apply_stimulus(0, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 5'd10);
    check_output("ws0_mis_flag", 32'(wb_mis0), 32'h1);
    check_output("ws0_mis_load", wb_load0, 32'h0);
    apply_stimulus(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h12, 32'h11111111, 5'd11);
    apply_stimulus(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 5'd12);
    check_output("ws0_size11_unchanged", wb_load0, 32'h80ADBEEF);

    // Store right behind a load, then address wrap modulo DEPTH.
    apply_stimulus(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0BADF00D, 5'd13);
    apply_stimulus(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd14);
    check_output("ws0_after_store", wb_load0, 32'h0BADF00D);
    apply_stimulus(0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h410, 32'h55AA00FF, 5'd15);
    apply_stimulus(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd16);
    check_output("ws0_wrap", wb_load0, 32'h55AA00FF);

    // Branch resolution.
    e = '{alu: 32'h44, load: 32'h0, rd: 5'd7, mis: 1'b0};
    push_exp(0, e);
    s0 = '0;
    s0.in_valid = 1'b1; s0.alu_result = 32'h44; s0.rd = 5'd7;
    s0.branch = 1'b1; s0.zero = 1'b1; s0.pc_branch = 32'h0000_1234;
    #1;
    check_output("beq_taken", 32'(pc_src0), 32'h1);
    check_output("branch_target", pcb0, 32'h0000_1234);
    @(posedge clock);
    #1;
    push_exp(0, e);
    s0.branch_ne = 1'b1;
    #1;
    check_output("bne_not_taken", 32'(pc_src0), 32'h0);
    @(posedge clock);
    #1;
    s0.in_valid = 1'b0;
    s0.branch_ne = 1'b0;
    #1;
    check_output("branch_invalid", 32'(pc_src0), 32'h0);
    @(posedge clock);
    #1;

    // Three wait states.
    apply_stimulus(3, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 5'd17);
    apply_stimulus(3, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 5'd18);
    check_output("ws3_load_word", wb_load3, 32'hCAFEF00D);
    apply_stimulus(3, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h99, 32'h0, 5'd19);
    apply_stimulus(3, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 5'd20);
    check_output("ws3_mis_flag", 32'(wb_mis3), 32'h1);

    // Reset in the middle of a waiting store drops the write.
    s3 = '0;
    s3.in_valid = 1'b1; s3.alu_result = 32'h20; s3.store_data = 32'h12345678;
    s3.mem_write = 1'b1; s3.mem_size = SZ_WORD; s3.rd = 5'd21;
    @(negedge clock);
    check_output("rst_wait_stall1", 32'(stall3), 32'h1);
    @(posedge clock);
    #1;
    check_output("rst_wait_stall2", 32'(stall3), 32'h1);
    reset_n = 1'b0;
    s3 = '0;
    #1;
    check_output("midrst_stall", 32'(stall3), 32'h0);
    check_output("midrst_wb_alu", wb_alu3, 32'h0);
    check_output("midrst_wb_rd", 32'(wb_rd3), 32'h0);
    check_output("midrst_wb_mis", 32'(wb_mis3), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    apply_stimulus(3, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 5'd22);
    check_output("ws3_store_dropped", wb_load3, 32'hCAFEF00D);
    apply_stimulus(3, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h7F, 5'd23);
    apply_stimulus(3, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 5'd24);
    check_output("ws3_load_sbyte_pos", wb_load3, 32'h0000007F);

    repeat (3) @(posedge clock);
    #1;
    check_output("q0_drained", q0.size(), 32'h0);
    check_output("q3_drained", q3.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
